// File: rtl/onecold_rr_arbiter_if.sv
//==============================================================================
// Module      : onecold_rr_arbiter_if
// Description : Request/grant bundle between the requesters and the arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface onecold_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] gnt_n;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    // Requester side drives requests and observes the grant.
    modport master (
        output req,
        input  gnt_n,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    // Arbiter side consumes requests and drives the grant.
    modport slave (
        input  req,
        output gnt_n,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

`default_nettype wire

// File: rtl/onecold_rr_arbiter.sv
//==============================================================================
// Module      : onecold_rr_arbiter
// Description : 8-way round-robin arbiter, one-cold registered grant with
//               break-before-make gap and optional hold timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module onecold_rr_arbiter #(
    parameter int MAX_HOLD   = 15,
    parameter int GAP_CYCLES = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    onecold_rr_arbiter_if.slave  bus
);

    localparam int              HOLD_W     = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] c_max_hold = HOLD_W'(MAX_HOLD);
    localparam logic [3:0]        c_gap      = 4'(GAP_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t            r_state;
    logic [7:0]        r_gnt_n;
    logic [2:0]        r_gnt_idx;
    logic              r_gnt_valid;
    logic              r_timeout;
    logic [2:0]        r_last;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [3:0]        r_gap_cnt;

    logic              w_win_found;
    logic [2:0]        w_win_idx;

    // Search starts just after the previous winner and wraps 7 -> 0.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = r_last;
        for (int k = 1; k <= 8; k++) begin
            if (!w_win_found && bus.req[r_last + 3'(k)]) begin
                w_win_found = 1'b1;
                w_win_idx   = r_last + 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt_n     <= 8'hFF;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_last      <= 3'd7;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= 4'd0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_found) begin
                        r_state     <= ST_ACTIVE;
                        r_gnt_n     <= ~(8'b1 << w_win_idx);
                        r_gnt_idx   <= w_win_idx;
                        r_gnt_valid <= 1'b1;
                        r_last      <= w_win_idx;
                        r_hold_cnt  <= HOLD_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    // A voluntary release wins over a coincident timeout.
                    if (!bus.req[r_gnt_idx] ||
                        ((MAX_HOLD != 0) && (r_hold_cnt == c_max_hold))) begin
                        r_state     <= ST_GAP;
                        r_gnt_n     <= 8'hFF;
                        r_gnt_valid <= 1'b0;
                        r_gap_cnt   <= 4'd1;
                        r_timeout   <= bus.req[r_gnt_idx];
                    end else if (r_hold_cnt != {HOLD_W{1'b1}}) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt >= c_gap) begin
                        r_state   <= ST_IDLE;
                        r_gap_cnt <= 4'd0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt_n     <= 8'hFF;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_n     = r_gnt_n;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_onecold_rr_arbiter.sv
//==============================================================================
// Module      : tb_onecold_rr_arbiter
// Description : Directed and random-stimulus bench for onecold_rr_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_onecold_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    onecold_rr_arbiter_if bus ();

    onecold_rr_arbiter #(
        .MAX_HOLD   (15),
        .GAP_CYCLES (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 8'h00;
        tick();
        rst     = 1'b0;
    endtask

    task automatic test_reset();
        bus.req = 8'h00;
        rst     = 1'b1;
        tick();
        n_cmp++;
        if (bus.gnt_n !== 8'hFF) begin
            n_err++; $display("FAIL reset_gnt_n: got %h expected ff", bus.gnt_n);
        end
        n_cmp++;
        if (bus.gnt_idx !== 3'd0) begin
            n_err++; $display("FAIL reset_gnt_idx: got %0d expected 0", bus.gnt_idx);
        end
        n_cmp++;
        if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: valid=%b timeout=%b expected 0 0", bus.gnt_valid, bus.timeout);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 8'h01;
        tick();
        n_cmp++;
        if (bus.gnt_n !== 8'hFE || bus.gnt_idx !== 3'd0 || bus.gnt_valid !== 1'b1) begin
            n_err++; $display("FAIL single_grant: gnt_n=%h idx=%0d valid=%b expected fe 0 1", bus.gnt_n, bus.gnt_idx, bus.gnt_valid);
        end
        tick();
        tick();
        bus.req = 8'h00;
        tick();
        n_cmp++;
        if (bus.gnt_n !== 8'hFF || bus.gnt_valid !== 1'b0) begin
            n_err++; $display("FAIL single_gap: gnt_n=%h valid=%b expected ff 0", bus.gnt_n, bus.gnt_valid);
        end
        bus.req = 8'h01;
        tick();
        n_cmp++;
        if (bus.gnt_n !== 8'hFF || bus.gnt_idx !== 3'd0) begin
            n_err++; $display("FAIL single_idle: gnt_n=%h idx=%0d expected ff 0", bus.gnt_n, bus.gnt_idx);
        end
        tick();
        n_cmp++;
        if (bus.gnt_n !== 8'hFE || bus.gnt_valid !== 1'b1) begin
            n_err++; $display("FAIL single_regrant: gnt_n=%h valid=%b expected fe 1", bus.gnt_n, bus.gnt_valid);
        end
        bus.req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_rotation();
        logic [7:0] exp_n;
        logic [2:0] e;
        logic       got;
        do_reset();
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            e     = 3'(k % 8);
            exp_n = ~(8'b1 << e);
            got   = 1'b0;
            for (int t = 0; t < 6 && !got; t++) begin
                tick();
                if (bus.gnt_valid === 1'b1) got = 1'b1;
            end
            n_cmp++;
            if (!got || bus.gnt_n !== exp_n || bus.gnt_idx !== e) begin
                n_err++; $display("FAIL rotation_grant_%0d: gnt_n=%h idx=%0d expected %h %0d", k, bus.gnt_n, bus.gnt_idx, exp_n, e);
            end
            tick();
            tick();
            bus.req = 8'hFF & ~(8'b1 << e);
            tick();
            n_cmp++;
            if (bus.gnt_n !== 8'hFF) begin
                n_err++; $display("FAIL rotation_release_%0d: gnt_n=%h expected ff", k, bus.gnt_n);
            end
            bus.req = 8'hFF;
        end
        bus.req = 8'h00;
        tick();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        logic [7:0] exp_n;
        logic [2:0] e;
        logic       got;
        do_reset();
        bus.req = 8'h24;
        for (int j = 0; j < 3; j++) begin
            e     = (j == 1) ? 3'd5 : 3'd2;
            exp_n = ~(8'b1 << e);
            got   = 1'b0;
            for (int t = 0; t < 6 && !got; t++) begin
                tick();
                if (bus.gnt_valid === 1'b1) got = 1'b1;
            end
            n_cmp++;
            if (!got || bus.gnt_n !== exp_n || bus.gnt_idx !== e) begin
                n_err++; $display("FAIL timeout_grant_%0d: gnt_n=%h idx=%0d expected %h %0d", j, bus.gnt_n, bus.gnt_idx, exp_n, e);
            end
            for (int c = 2; c <= 15; c++) begin
                tick();
                n_cmp++;
                if (bus.gnt_n !== exp_n || bus.timeout !== 1'b0) begin
                    n_err++; $display("FAIL timeout_hold_%0d_c%0d: gnt_n=%h timeout=%b expected %h 0", j, c, bus.gnt_n, bus.timeout, exp_n);
                end
            end
            tick();
            n_cmp++;
            if (bus.gnt_n !== 8'hFF || bus.timeout !== 1'b1) begin
                n_err++; $display("FAIL timeout_pulse_%0d: gnt_n=%h timeout=%b expected ff 1", j, bus.gnt_n, bus.timeout);
            end
            tick();
            n_cmp++;
            if (bus.gnt_n !== 8'hFF || bus.timeout !== 1'b0) begin
                n_err++; $display("FAIL timeout_pulse_end_%0d: gnt_n=%h timeout=%b expected ff 0", j, bus.gnt_n, bus.timeout);
            end
        end
        bus.req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_release_at_max();
        do_reset();
        bus.req = 8'h01;
        tick();
        n_cmp++;
        if (bus.gnt_n !== 8'hFE) begin
            n_err++; $display("FAIL relmax_grant: gnt_n=%h expected fe", bus.gnt_n);
        end
        for (int c = 2; c <= 15; c++) tick();
        bus.req = 8'h00;
        tick();
        n_cmp++;
        if (bus.gnt_n !== 8'hFF || bus.timeout !== 1'b0) begin
            n_err++; $display("FAIL relmax_release: gnt_n=%h timeout=%b expected ff 0", bus.gnt_n, bus.timeout);
        end
        tick();
        n_cmp++;
        if (bus.gnt_n !== 8'hFF || bus.timeout !== 1'b0) begin
            n_err++; $display("FAIL relmax_gap: gnt_n=%h timeout=%b expected ff 0", bus.gnt_n, bus.timeout);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.req = 8'h10;
        tick();
        n_cmp++;
        if (bus.gnt_n !== 8'hEF || bus.gnt_idx !== 3'd4) begin
            n_err++; $display("FAIL midrst_grant: gnt_n=%h idx=%0d expected ef 4", bus.gnt_n, bus.gnt_idx);
        end
        tick();
        rst     = 1'b1;
        bus.req = 8'hFF;
        tick();
        n_cmp++;
        if (bus.gnt_n !== 8'hFF || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 3'd0) begin
            n_err++; $display("FAIL midrst_reset: gnt_n=%h valid=%b idx=%0d expected ff 0 0", bus.gnt_n, bus.gnt_valid, bus.gnt_idx);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (bus.gnt_n !== 8'hFE || bus.gnt_idx !== 3'd0 || bus.gnt_valid !== 1'b1) begin
            n_err++; $display("FAIL midrst_first: gnt_n=%h idx=%0d valid=%b expected fe 0 1", bus.gnt_n, bus.gnt_idx, bus.gnt_valid);
        end
        bus.req = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       prev_valid;
        int         pending [8];
        int         worst;
        do_reset();
        r          = 8'h00;
        prev_valid = 1'b0;
        for (int i = 0; i < 8; i++) pending[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(7) == 0) r[i] = ~r[i];
                if (!r[i]) pending[i] = 0;
            end
            bus.req = r;
            tick();
            n_cmp++;
            if (!(bus.gnt_n === 8'hFF || $onehot(~bus.gnt_n)) ||
                (bus.gnt_valid !== (bus.gnt_n != 8'hFF)) ||
                (bus.gnt_valid && bus.gnt_n[bus.gnt_idx] !== 1'b0) ||
                (bus.timeout && bus.gnt_valid)) begin
                n_err++; $display("FAIL random_invariant cyc %0d: gnt_n=%h valid=%b idx=%0d timeout=%b", cyc, bus.gnt_n, bus.gnt_valid, bus.gnt_idx, bus.timeout);
            end
            if (bus.gnt_valid && !prev_valid) begin
                worst = 0;
                for (int i = 0; i < 8; i++) begin
                    if (i == int'(bus.gnt_idx)) pending[i] = 0;
                    else if (r[i]) pending[i]++;
                    if (pending[i] > worst) worst = pending[i];
                end
                n_cmp++;
                if (worst >= 8) begin
                    n_err++; $display("FAIL random_starvation cyc %0d: waited %0d grants, required below 8", cyc, worst);
                end
            end
            prev_valid = bus.gnt_valid;
        end
        bus.req = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        bus.req = 8'h00;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_release_at_max();
        test_reset_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
